// File: rtl/stream_window_averager.sv
// Turns the accumulator's running sum into one rounded, saturated average per window of 2**LOG2_N samples.
// Results wait in a small valid/ready output FIFO; a full FIFO drops the new result and sets a sticky overflow flag.
module stream_window_averager #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int LOG2_N     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   sum_in,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOG2_N-1:0] win_count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IN_W-1:0]  base;
  logic [IN_W-1:0]  diff;
  logic             s1_vld;
  logic             s2_vld;
  logic [OUT_W-1:0] s2_data;
  logic [IN_W:0]    rounded;
  logic [IN_W:0]    avg_wide;
  logic [OUT_W-1:0] avg_sat;

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             do_push;

  // One extra bit keeps the rounding carry of a near-full-scale diff.
  always_comb begin
    rounded  = {1'b0, diff} + ((IN_W+1)'(1) << (LOG2_N - 1));
    avg_wide = rounded >> LOG2_N;
    avg_sat  = avg_wide[OUT_W-1:0];
    if (avg_wide > (IN_W+1)'({OUT_W{1'b1}})) begin
      avg_sat = '1;
    end
  end

  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign do_push   = s2_vld && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // The window sum is the difference between successive snapshots.
  // Unsigned subtraction tolerates the accumulator wrapping around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base      <= '0;
      diff      <= '0;
      win_count <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s2_data   <= '0;
    end else if (clear) begin
      base      <= '0;
      diff      <= '0;
      win_count <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s2_data   <= '0;
    end else begin
      s1_vld  <= 1'b0;
      s2_vld  <= s1_vld;
      s2_data <= avg_sat;
      if (in_valid) begin
        win_count <= win_count + 1'b1;
        if (win_count == '1) begin
          diff   <= sum_in - base;
          base   <= sum_in;
          s1_vld <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= s2_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end else if (s2_vld) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_stream_window_averager.sv
// Directed bench for stream_window_averager: expected averages go into a queue.
// A free-running monitor pops the queue and checks every accepted output.
module tb_stream_window_averager;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [31:0] sum_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  win_count;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  stream_window_averager #(.IN_W(32), .OUT_W(16), .LOG2_N(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .sum_in(sum_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .win_count(win_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // A handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_output got %0h expected nothing", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          miscompares++;
          $display("[TB] FAIL pop_data got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] value);
    in_valid = 1'b1;
    sum_in   = value;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_window(input logic [31:0] close_sum);
    for (int i = 1; i <= 15; i++) applyStimulus(32'(i));
    applyStimulus(close_sum);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; sum_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_win_count", 32'(win_count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] T1/T2 basic and consecutive windows");
    out_ready = 1'b1;
    for (int k = 1; k <= 15; k++) applyStimulus(32'(k * (k + 1) / 2));
    exp_q.push_back(16'd9);
    applyStimulus(32'd136);
    checkOutput("t1_lat_edge0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_lat_edge1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_lat_edge2", 32'(out_valid), 32'd1);
    checkOutput("t1_data", 32'(out_data), 32'd9);
    for (int k = 17; k <= 31; k++) applyStimulus(32'(k * (k + 1) / 2));
    exp_q.push_back(16'd25);
    applyStimulus(32'd528);
    wait_drain("t2_drain");
    checkOutput("t2_win_count", 32'(win_count), 32'd0);

    $display("[TB] T3 wrap and saturation");
    do_clear();
    exp_q.push_back(16'hFFFF);
    run_window(32'hFFFF_FFF8);
    exp_q.push_back(16'd8);
    run_window(32'h0000_0078);
    wait_drain("t3_drain");

    $display("[TB] T4 backpressure");
    do_clear();
    out_ready = 1'b0;
    exp_q.push_back(16'd10);
    run_window(32'd160);
    exp_q.push_back(16'd20);
    run_window(32'd480);
    checkOutput("t4_no_ovf_yet", 32'(overflow), 32'd0);
    run_window(32'd960);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_overflow", 32'(overflow), 32'd1);
    checkOutput("t4_held_valid", 32'(out_valid), 32'd1);
    checkOutput("t4_held_data", 32'(out_data), 32'd10);
    out_ready = 1'b1;
    wait_drain("t4_drain");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t4_sticky_ovf", 32'(overflow), 32'd1);
    checkOutput("t4_empty", 32'(out_valid), 32'd0);

    $display("[TB] T5 clear mid-window");
    do_clear();
    checkOutput("t5_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 1; i <= 7; i++) applyStimulus(32'(i * 3));
    checkOutput("t5_count7", 32'(win_count), 32'd7);
    clear = 1'b1; in_valid = 1'b1; sum_in = 32'd999;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    checkOutput("t5_count0", 32'(win_count), 32'd0);
    for (int i = 1; i <= 15; i++) applyStimulus(32'(20 * i));
    exp_q.push_back(16'd20);
    applyStimulus(32'd320);
    wait_drain("t5_drain");

    $display("[TB] T6 reset mid-operation");
    out_ready = 1'b0;
    run_window(32'd160);
    run_window(32'd480);
    checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t6_post_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_post_count", 32'(win_count), 32'd0);
    exp_q.push_back(16'd10);
    run_window(32'd160);
    wait_drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
